serial_full_subtractor: RTL

- Bit-serial N-bit subtractor built around one full-subtractor cell and a registered borrow flip-flop. It is the inverse companion of the full-adder cell.
- Captures operands on a start handshake and processes one bit per clock, LSB first, emitting each difference bit as it goes.
- On completion it presents the parallel difference and final borrow.
- Used by the lab datapath wherever area matters more than latency.

---
 rtl/serial_full_subtractor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a registered borrow,
// one bit per clock LSB first, with parallel result and final borrow on completion.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             bit_valid,
  output logic             Diff_bit,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             d_s;
  logic             bo_s;
  logic             busy_r;
  logic             bit_valid_r;
  logic             diff_bit_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             done_r;

  // Full-subtractor cell: returns {borrow_out, difference}
  function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  // Cell evaluation on the current operand LSBs and the stored borrow
  always_comb begin
    {bo_s, d_s} = fs_cell(a_r[0], b_r[0], br_r);
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered outputs; start is only honoured in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      br_r        <= 1'b0;
      busy_r      <= 1'b0;
      bit_valid_r <= 1'b0;
      diff_bit_r  <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s == SHIFT);
      case (state_r)
        IDLE: begin
          done_r      <= 1'b0;
          bit_valid_r <= 1'b0;
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            br_r  <= Bin;
            cnt_r <= {CW{1'b0}};
          end
        end
        SHIFT: begin
          done_r      <= 1'b0;
          bit_valid_r <= 1'b1;
          diff_bit_r  <= d_s;
          br_r        <= bo_s;
          res_r       <= {d_s, res_r[WIDTH-1:1]};
          a_r         <= {1'b0, a_r[WIDTH-1:1]};
          b_r         <= {1'b0, b_r[WIDTH-1:1]};
          cnt_r       <= cnt_r + CW'(1);
        end
        DONE: begin
          done_r      <= 1'b1;
          bit_valid_r <= 1'b0;
          diff_r      <= res_r;
          bout_r      <= br_r;
        end
        default: begin
          done_r      <= 1'b0;
          bit_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign bit_valid = bit_valid_r;
  assign Diff_bit  = diff_bit_r;
  assign Diff      = diff_r;
  assign Bout      = bout_r;
  assign done      = done_r;

endmodule
